// File: rtl/frame_aligner_param.sv
// Parametrised serial frame aligner: hunts for the frame alignment word (FAW),
// confirms it over SYNC_N frames, flywheels through up to LOSS_N-1 errored FAWs,
// and deserialises the in-sync payload into PAR_W-bit words (first bit in MSB).
module frame_aligner_param #(
    parameter int unsigned        FAW_LEN   = 10,
    parameter logic [FAW_LEN-1:0] FAW       = 10'b1111010000,
    parameter int unsigned        FRAME_LEN = 1536,
    parameter int unsigned        PAR_W     = 7,
    parameter int unsigned        SYNC_N    = 3,
    parameter int unsigned        LOSS_N    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in,
    input  logic                         bit_en,
    output logic                         sync,
    output logic                         frame_start,
    output logic                         loss,
    output logic [$clog2(FRAME_LEN)-1:0] bit_cnt,
    output logic [PAR_W-1:0]             par_out,
    output logic                         par_valid,
    output logic [1:0]                   state
);

    localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
    localparam int unsigned HIT_W     = $clog2(SYNC_N + 1);
    localparam int unsigned MISS_W    = $clog2(LOSS_N + 1);
    localparam int unsigned ACC_CNT_W = $clog2(PAR_W + 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PRESYNC = 2'd1,
        ST_SYNC    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [FAW_LEN-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]       bit_cnt_d;
    logic [HIT_W-1:0]       hit_q, hit_d;
    logic [MISS_W-1:0]      miss_q, miss_d;
    logic [PAR_W-1:0]       acc_q, acc_d;
    logic [ACC_CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [PAR_W-1:0]       par_out_d;
    logic                   par_valid_d;
    logic                   frame_start_d;
    logic                   loss_d;
    logic                   sync_d;

    logic [FAW_LEN-1:0]     shifted;
    logic                   match;
    logic                   checkpoint;
    logic [CNT_W-1:0]       cnt_inc;
    logic [HIT_W-1:0]       hit_inc;
    logic [MISS_W-1:0]      miss_inc;
    logic [PAR_W-1:0]       acc_shift;
    logic                   acc_full;
    logic                   in_payload;

    // Window including the bit being accepted, frame position and counter increments
    always_comb begin
        shifted    = (sr_q << 1) | FAW_LEN'(in);
        match      = bit_en & (shifted == FAW);
        checkpoint = bit_en & (bit_cnt == CNT_W'(FAW_LEN - 1));
        cnt_inc    = (bit_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : bit_cnt + CNT_W'(1);
        hit_inc    = hit_q + HIT_W'(1);
        miss_inc   = miss_q + MISS_W'(1);
        acc_shift  = (acc_q << 1) | PAR_W'(in);
        acc_full   = (acc_cnt_q == ACC_CNT_W'(PAR_W - 1));
        in_payload = (bit_cnt >= CNT_W'(FAW_LEN));
    end

    // Next-state and registered-output decode; nothing advances without bit_en
    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt;
        hit_d         = hit_q;
        miss_d        = miss_q;
        acc_d         = acc_q;
        acc_cnt_d     = acc_cnt_q;
        par_out_d     = par_out;
        par_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        loss_d        = 1'b0;

        if (bit_en) begin
            sr_d = shifted;
            case (state_q)
                ST_HUNT: begin
                    bit_cnt_d = '0;
                    hit_d     = '0;
                    miss_d    = '0;
                    if (match) begin
                        bit_cnt_d = CNT_W'(FAW_LEN);
                        hit_d     = HIT_W'(1);
                        if (SYNC_N == 1) begin
                            state_d       = ST_SYNC;
                            frame_start_d = 1'b1;
                        end else begin
                            state_d = ST_PRESYNC;
                        end
                    end
                end
                ST_PRESYNC: begin
                    bit_cnt_d = cnt_inc;
                    if (checkpoint) begin
                        if (match) begin
                            hit_d = hit_inc;
                            if (hit_inc == HIT_W'(SYNC_N)) begin
                                state_d       = ST_SYNC;
                                miss_d        = '0;
                                frame_start_d = 1'b1;
                            end
                        end else begin
                            // Candidate rejected: restart the hunt from the next bit
                            state_d   = ST_HUNT;
                            bit_cnt_d = '0;
                            hit_d     = '0;
                            miss_d    = '0;
                        end
                    end
                end
                ST_SYNC: begin
                    bit_cnt_d = cnt_inc;
                    if (checkpoint) begin
                        if (match) begin
                            miss_d        = '0;
                            frame_start_d = 1'b1;
                        end else if (miss_inc == MISS_W'(LOSS_N)) begin
                            state_d   = ST_HUNT;
                            loss_d    = 1'b1;
                            bit_cnt_d = '0;
                            hit_d     = '0;
                            miss_d    = '0;
                        end else begin
                            // Flywheel: tolerate the errored FAW and stay framed
                            miss_d        = miss_inc;
                            frame_start_d = 1'b1;
                        end
                    end else if (in_payload) begin
                        acc_d = acc_shift;
                        if (acc_full) begin
                            par_out_d   = acc_shift;
                            par_valid_d = 1'b1;
                            acc_d       = '0;
                            acc_cnt_d   = '0;
                        end else begin
                            acc_cnt_d = acc_cnt_q + ACC_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d   = ST_HUNT;
                    bit_cnt_d = '0;
                    hit_d     = '0;
                    miss_d    = '0;
                end
            endcase

            // Payload word boundaries restart at every FAW and whenever framing is lost
            if (checkpoint || (state_d != ST_SYNC)) begin
                acc_d     = '0;
                acc_cnt_d = '0;
            end
        end

        sync_d = (state_d == ST_SYNC);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            sr_q        <= '0;
            bit_cnt     <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            par_out     <= '0;
            par_valid   <= 1'b0;
            frame_start <= 1'b0;
            loss        <= 1'b0;
            sync        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt     <= bit_cnt_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            par_out     <= par_out_d;
            par_valid   <= par_valid_d;
            frame_start <= frame_start_d;
            loss        <= loss_d;
            sync        <= sync_d;
        end
    end

    assign state = state_q;

endmodule
